// File: rtl/rv_fetch_unit_pkg.sv
// Shared types for the instruction fetch stage.
package rv_fetch_unit_pkg;

    typedef logic [31:0] OperandType;
    typedef logic [31:0] RV32InstType;

    typedef struct packed {
        OperandType  pc;
        RV32InstType inst;
    } FetchEntryType;

    localparam RV32InstType NOP_INST = 32'h0000_0013;

endpackage

// File: rtl/rv_fetch_fifo.sv
// Synchronous first-word-fall-through FIFO with flush; push and pop may coincide at any occupancy.
module rv_fetch_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter type         T     = logic [31:0]
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         push_i,
    input  T                             data_i,
    input  logic                         pop_i,
    input  logic                         flush_i,
    output T                             data_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o,
    output logic                         full_o,
    output logic                         empty_o
);

    localparam int unsigned CntW = $clog2(DEPTH + 1);
    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    T                mem_q [DEPTH];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic            do_push, do_pop;

    function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
        return (p == PtrW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CntW'(DEPTH));
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];

    assign do_pop  = pop_i & ~empty_o;
    // A pop frees the slot the push needs, so a full FIFO still accepts a push alongside a pop.
    assign do_push = push_i & (~full_o | do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = next_ptr(wr_ptr_q);
            if (do_pop)  rd_ptr_d = next_ptr(rd_ptr_q);
            count_d = count_q + CntW'(do_push) - CntW'(do_pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push && !flush_i) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/rv_fetch_unit.sv
// Instruction fetch stage: credit-limited imem requests, prefetch FIFO and redirect handling.
// Optional performance counters are enabled by defining RV_FETCH_PERF_EN.
module rv_fetch_unit
    import rv_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH      = 4,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        rst,
    output OperandType  PC,
    output RV32InstType Inst,
    output logic        isInstValid,
    input  logic        FetchStall,
    input  logic        FetchJump,
    input  logic [31:0] TargetPC,
    output logic        ImemReq,
    output logic [31:0] ImemAddr,
    input  logic        ImemGnt,
    input  logic        ImemRvalid,
    input  logic [31:0] ImemRdata
`ifdef RV_FETCH_PERF_EN
    ,
    output logic [31:0] FetchStallCnt,
    output logic [31:0] FetchRedirectCnt
`endif
);

    localparam int unsigned OutW = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned FCntW = $clog2(FIFO_DEPTH + 1);

    logic [31:0]     fetch_pc_q, fetch_pc_d;
    logic [OutW-1:0] outstanding_q, outstanding_d;
    logic [OutW-1:0] discard_q, discard_d;

    FetchEntryType   fifo_head, fifo_in;
    logic [FCntW-1:0] fifo_count;
    logic            fifo_full, fifo_empty, fifo_push, fifo_pop;

    OperandType      pcq_head;
    logic [OutW-1:0] pcq_count;
    logic            pcq_full, pcq_empty;

    logic            grant;

    assign ImemReq = ~rst & ~FetchJump
                   & (outstanding_q < OutW'(MAX_OUTSTANDING))
                   & ((32'(outstanding_q) + 32'(fifo_count)) < FIFO_DEPTH);
    assign ImemAddr = fetch_pc_q;
    assign grant    = ImemReq & ImemGnt;

    assign isInstValid = ~rst & ~fifo_empty & ~FetchJump;
    assign PC          = rst ? '0 : fifo_head.pc;
    assign Inst        = rst ? '0 : fifo_head.inst;

    assign fifo_pop  = isInstValid & ~FetchStall;
    assign fifo_push = ImemRvalid & (discard_q == '0) & ~FetchJump;
    assign fifo_in   = '{pc: pcq_head, inst: ImemRdata};

    rv_fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .T     (FetchEntryType)
    ) u_prefetch_fifo (
        .clk_i   (clk),
        .rst_i   (rst),
        .push_i  (fifo_push),
        .data_i  (fifo_in),
        .pop_i   (fifo_pop),
        .flush_i (FetchJump),
        .data_o  (fifo_head),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // In-flight request addresses; never flushed, since wrong-path responses still return.
    rv_fetch_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .T     (OperandType)
    ) u_pc_queue (
        .clk_i   (clk),
        .rst_i   (rst),
        .push_i  (grant),
        .data_i  (fetch_pc_q),
        .pop_i   (ImemRvalid),
        .flush_i (1'b0),
        .data_o  (pcq_head),
        .count_o (pcq_count),
        .full_o  (pcq_full),
        .empty_o (pcq_empty)
    );

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        outstanding_d = outstanding_q + OutW'(grant) - OutW'(ImemRvalid);
        discard_d     = discard_q;
        if (FetchJump) begin
            fetch_pc_d = {TargetPC[31:2], 2'b00};
            discard_d  = outstanding_d;
        end else begin
            if (grant) fetch_pc_d = fetch_pc_q + 32'd4;
            if (ImemRvalid && discard_q != '0) discard_d = discard_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q    <= RESET_PC;
            outstanding_q <= '0;
            discard_q     <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
        end
    end

`ifdef RV_FETCH_PERF_EN
    logic [31:0] stall_cnt_q, redirect_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q    <= '0;
            redirect_cnt_q <= '0;
        end else begin
            if (isInstValid && FetchStall && stall_cnt_q != '1) stall_cnt_q <= stall_cnt_q + 32'd1;
            if (FetchJump && redirect_cnt_q != '1) redirect_cnt_q <= redirect_cnt_q + 32'd1;
        end
    end

    assign FetchStallCnt    = stall_cnt_q;
    assign FetchRedirectCnt = redirect_cnt_q;
`endif

    assert property (@(posedge clk) disable iff (rst)
        !(ImemRvalid && fifo_full && discard_q == '0));
    assert property (@(posedge clk) disable iff (rst) !(ImemRvalid && pcq_empty));
    assert property (@(posedge clk) disable iff (rst) !(grant && pcq_full && !ImemRvalid));
    assert property (@(posedge clk) disable iff (rst) pcq_count == outstanding_q);

endmodule
